add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_pkg.sv | 18 +
 rtl/add_seq_adder.sv | 14 +
 rtl/add_seq.sv | 120 ++++++++++++
 tb/tb_add_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the word-serial adder/subtractor.
// State encoding and index-width helper used by add_seq.
package add_seq_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Word-index width for an N-word operand (N >= 2, so never below 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_adder.sv
// One-word ripple datapath: S = A + B + cin, carry out of the top bit on cout.
module add_seq_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
    output logic [W-1:0] S,
    output logic         cout
);

    assign {cout, S} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// Word-serial N*W-bit add/subtract: one W-bit word per RUN cycle, carry kept in a register.
// Result, carry and signed overflow are held registered until the consumer accepts them.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] s,
    output logic           cout,
    output logic           ovf
);

    localparam int unsigned IW = idx_width(N);
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    state_e         state_q;
    logic [N*W-1:0] a_q, b_q, s_q;
    logic           sub_q, carry_q, cout_q, ovf_q, out_valid_q;
    logic [IW-1:0]  idx_q;

    logic [W-1:0]   word_a, word_b, word_s;
    logic           word_c;
    logic           ovf_next;

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx_q == IW'(k)) begin
                word_a = a_q[k*W +: W];
                word_b = b_q[k*W +: W];
            end
        end
        word_b = word_b ^ {W{sub_q}};
    end

    add_seq_adder #(
        .W (W)
    ) u_adder (
        .A    (word_a),
        .B    (word_b),
        .cin  (carry_q),
        .S    (word_s),
        .cout (word_c)
    );

    // Only meaningful on the terminal word, where word_s holds the result MSB.
    assign ovf_next = (a_q[N*W-1] == (b_q[N*W-1] ^ sub_q)) && (word_s[W-1] != a_q[N*W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        idx_q   <= '0;
                        carry_q <= sub;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    for (int k = 0; k < int'(N); k++) begin
                        if (idx_q == IW'(k)) begin
                            s_q[k*W +: W] <= word_s;
                        end
                    end
                    carry_q <= word_c;
                    if (idx_q == LastIdx) begin
                        cout_q  <= word_c;
                        ovf_q   <= ovf_next;
                        idx_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                StDone: begin
                    // First DONE cycle raises out_valid; handshake is taken only once it is up.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Directed-vector and randomized bench for add_seq at W=8, N=4.
module tb_add_seq;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    add_seq #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_op(input logic [31:0] ra, input logic [31:0] rb, input logic rsub,
                          output logic [31:0] rs, output logic rc, output logic rv);
        logic [32:0] full;
        logic [31:0] bp;
        bp   = rb ^ {32{rsub}};
        full = {1'b0, ra} + {1'b0, bp} + {32'd0, rsub};
        rs   = full[31:0];
        rc   = full[32];
        rv   = (ra[31] == bp[31]) && (rs[31] != ra[31]);
    endtask

    // Wait for out_valid after the accept edge; returns edges elapsed (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic vsub, input logic [31:0] es, input logic ec,
                          input logic ev);
        int lat;
        check({nm, " ready"}, {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        sub      = vsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({nm, " busy"}, {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check({nm, " latency"}, lat, 32'd5);
        check({nm, " s"}, s, es);
        check({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
        check({nm, " ovf"}, {31'd0, ovf}, {31'd0, ev});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rs;
        logic        rc, rv;
        logic [31:0] ra, rb;
        logic        rsub;
        logic [31:0] hold_s;
        int          lat;
        int          seen;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        repeat (3) tick();
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst s", s, 32'd0);
        check("rst cout", {31'd0, cout}, 32'd0);
        check("rst ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].s, vecs[i].cout, vecs[i].ovf);
        end

        // Result must stay put in IDLE after the handshake.
        tick();
        check("idle hold s", s, 32'h0000_0000);
        check("idle hold cout", {31'd0, cout}, 32'd1);

        // Backpressure: new operands offered while DONE is stalled.
        a        = 32'h1122_3344;
        b        = 32'h0101_0101;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp first latency", lat, 32'd5);
        a        = 32'hAAAA_AAAA;
        b        = 32'h5555_5555;
        sub      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp stall s", s, 32'h1223_3445);
            check("bp stall in_ready", {31'd0, in_ready}, 32'd0);
            check("bp stall out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        check("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        check("bp idle s", s, 32'h1223_3445);
        tick();
        in_valid = 1'b0;
        check("bp second busy", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check("bp second latency", lat, 32'd5);
        check("bp second s", s, 32'h5555_5555);
        check("bp second cout", {31'd0, cout}, 32'd1);
        check("bp second ovf", {31'd0, ovf}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while word 2 is in flight.
        a        = 32'hDEAD_BEEF;
        b        = 32'h0123_4567;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst s", s, 32'd0);
        check("mid rst cout", {31'd0, cout}, 32'd0);
        check("mid rst ovf", {31'd0, ovf}, 32'd0);
        seen = 0;
        repeat (2) begin
            tick();
            if (out_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid rst no out_valid", seen, 32'd0);
        run_op("post rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            rsub = 1'($urandom_range(0, 1));
            ref_op(ra, rb, rsub, rs, rc, rv);
            run_op("rand", ra, rb, rsub, rs, rc, rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
